// File: rtl/mdu_issue_queue.sv
// In-order Hi/Lo pair issue queue for the MDU. It waits for both source pregs to be ready and
// reserves the MDU's two-cycle Hi/Lo writeback window so mul and div results never collide.
module mdu_iq_wake #(
  parameter int PREG_W = 6
) (
  input  logic [PREG_W-1:0]      src,
  input  logic [1:0]             wkValid,
  input  logic [1:0][PREG_W-1:0] wkPreg,
  output logic                   hit
);
  assign hit = (src == '0) ||
               (wkValid[0] && (wkPreg[0] == src)) ||
               (wkValid[1] && (wkPreg[1] == src));
endmodule

module mdu_issue_queue #(
  parameter int DEPTH   = 4,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8,
  parameter int PREG_W  = 6,
  parameter int ROBID_W = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [1:0]                 enq_op,
  input  logic [PREG_W-1:0]          enq_src0,
  input  logic [PREG_W-1:0]          enq_src1,
  input  logic                       enq_rdy0,
  input  logic                       enq_rdy1,
  input  logic [PREG_W-1:0]          enq_pdst_hi,
  input  logic [PREG_W-1:0]          enq_pdst_lo,
  input  logic [ROBID_W-1:0]         enq_id_hi,
  input  logic [ROBID_W-1:0]         enq_id_lo,
  input  logic [1:0]                 wk_valid,
  input  logic [1:0][PREG_W-1:0]     wk_preg,
  output logic [PREG_W-1:0]          prf_raddr0,
  output logic [PREG_W-1:0]          prf_raddr1,
  output logic                       iss_valid,
  output logic [1:0]                 iss_op,
  output logic [PREG_W-1:0]          iss_pdst_hi,
  output logic [PREG_W-1:0]          iss_pdst_lo,
  output logic [ROBID_W-1:0]         iss_id_hi,
  output logic [ROBID_W-1:0]         iss_id_lo,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int RES_W = DIV_LAT + 2;
  localparam logic [RES_W-1:0] PAIR     = RES_W'(3);
  localparam logic [RES_W-1:0] MUL_MASK = PAIR << MUL_LAT;
  localparam logic [RES_W-1:0] DIV_MASK = PAIR << DIV_LAT;

  typedef struct packed {
    logic [1:0]         op;
    logic [PREG_W-1:0]  src0;
    logic [PREG_W-1:0]  src1;
    logic [PREG_W-1:0]  pdstHi;
    logic [PREG_W-1:0]  pdstLo;
    logic [ROBID_W-1:0] idHi;
    logic [ROBID_W-1:0] idLo;
  } entry_t;

  entry_t             ent [DEPTH];
  logic [DEPTH-1:0]   vld, rdy0, rdy1, hit0, hit1;
  logic [PTR_W-1:0]   head, tail;
  logic [RES_W-1:0]   res, resShift;
  logic               enqHit0, enqHit1, enqFire, issue, mulFree, divFree;
  entry_t             headEnt;

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : gWake
      mdu_iq_wake #(.PREG_W(PREG_W)) uW0 (.src(ent[g].src0), .wkValid(wk_valid), .wkPreg(wk_preg), .hit(hit0[g]));
      mdu_iq_wake #(.PREG_W(PREG_W)) uW1 (.src(ent[g].src1), .wkValid(wk_valid), .wkPreg(wk_preg), .hit(hit1[g]));
    end
  endgenerate

  // Same-cycle wakeup for the pair being written so a broadcast is never lost.
  mdu_iq_wake #(.PREG_W(PREG_W)) uEnqW0 (.src(enq_src0), .wkValid(wk_valid), .wkPreg(wk_preg), .hit(enqHit0));
  mdu_iq_wake #(.PREG_W(PREG_W)) uEnqW1 (.src(enq_src1), .wkValid(wk_valid), .wkPreg(wk_preg), .hit(enqHit1));

  assign headEnt    = ent[head];
  assign prf_raddr0 = headEnt.src0;
  assign prf_raddr1 = headEnt.src1;
  assign enq_ready  = (count != CNT_W'(DEPTH));
  assign enqFire    = enq_valid && enq_ready;

  // Slot i of res means the MDU writeback port is taken i cycles from now.
  assign resShift = {1'b0, res[RES_W-1:1]};
  assign mulFree  = !resShift[MUL_LAT] && !resShift[MUL_LAT+1];
  assign divFree  = !resShift[DIV_LAT] && !resShift[DIV_LAT+1];
  assign issue    = vld[head] && rdy0[head] && rdy1[head] &&
                    (headEnt.op[1] ? divFree : mulFree);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      vld         <= '0;
      rdy0        <= '0;
      rdy1        <= '0;
      res         <= '0;
      iss_valid   <= 1'b0;
      iss_op      <= '0;
      iss_pdst_hi <= '0;
      iss_pdst_lo <= '0;
      iss_id_hi   <= '0;
      iss_id_lo   <= '0;
    end else begin
      res  <= resShift | (issue ? (headEnt.op[1] ? DIV_MASK : MUL_MASK) : '0);
      rdy0 <= rdy0 | (hit0 & vld);
      rdy1 <= rdy1 | (hit1 & vld);
      if (enqFire) begin
        ent[tail]  <= '{op: enq_op, src0: enq_src0, src1: enq_src1,
                        pdstHi: enq_pdst_hi, pdstLo: enq_pdst_lo,
                        idHi: enq_id_hi, idLo: enq_id_lo};
        vld[tail]  <= 1'b1;
        rdy0[tail] <= enq_rdy0 || enqHit0;
        rdy1[tail] <= enq_rdy1 || enqHit1;
        tail       <= tail + PTR_W'(1);
      end
      // Tail never aliases a valid head on enqueue, so this clear cannot fight the write above.
      if (issue) begin
        vld[head]   <= 1'b0;
        head        <= head + PTR_W'(1);
        iss_valid   <= 1'b1;
        iss_op      <= headEnt.op;
        iss_pdst_hi <= headEnt.pdstHi;
        iss_pdst_lo <= headEnt.pdstLo;
        iss_id_hi   <= headEnt.idHi;
        iss_id_lo   <= headEnt.idLo;
      end else begin
        iss_valid <= 1'b0;
      end
      case ({enqFire, issue})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_issue_queue.sv
// Directed bench for mdu_issue_queue: ready-path issue, reservation collisions, full queue,
// same-cycle wakeup and flush.
module tb_mdu_issue_queue;
  logic clk = 1'b0;
  logic rst, flush, enq_valid, enq_ready, enq_rdy0, enq_rdy1, iss_valid;
  logic [1:0] enq_op, wk_valid, iss_op;
  logic [5:0] enq_src0, enq_src1, enq_pdst_hi, enq_pdst_lo, enq_id_hi, enq_id_lo;
  logic [1:0][5:0] wk_preg;
  logic [5:0] prf_raddr0, prf_raddr1, iss_pdst_hi, iss_pdst_lo, iss_id_hi, iss_id_lo;
  logic [2:0] count;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mdu_issue_queue dut (
    .clk(clk), .rst(rst), .flush(flush), .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_op(enq_op), .enq_src0(enq_src0), .enq_src1(enq_src1), .enq_rdy0(enq_rdy0),
    .enq_rdy1(enq_rdy1), .enq_pdst_hi(enq_pdst_hi), .enq_pdst_lo(enq_pdst_lo),
    .enq_id_hi(enq_id_hi), .enq_id_lo(enq_id_lo), .wk_valid(wk_valid), .wk_preg(wk_preg),
    .prf_raddr0(prf_raddr0), .prf_raddr1(prf_raddr1), .iss_valid(iss_valid), .iss_op(iss_op),
    .iss_pdst_hi(iss_pdst_hi), .iss_pdst_lo(iss_pdst_lo), .iss_id_hi(iss_id_hi),
    .iss_id_lo(iss_id_lo), .count(count)
  );

  // Inputs change on negedge, outputs are sampled on the negedge after the active edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic setEnq(input logic [1:0] op, input logic [5:0] s0, input logic r0,
                        input logic [5:0] s1, input logic r1, input logic [5:0] id);
    enq_valid = 1'b1; enq_op = op;
    enq_src0 = s0; enq_rdy0 = r0; enq_src1 = s1; enq_rdy1 = r1;
    enq_pdst_hi = id; enq_pdst_lo = id + 6'd1; enq_id_hi = id; enq_id_lo = id + 6'd32;
  endtask

  task automatic idle(input int n);
    enq_valid = 1'b0; wk_valid = 2'b00;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; enq_valid = 1'b0; wk_valid = 2'b00; wk_preg = '0;
    enq_op = 2'd0; enq_src0 = '0; enq_src1 = '0; enq_rdy0 = 1'b0; enq_rdy1 = 1'b0;
    enq_pdst_hi = '0; enq_pdst_lo = '0; enq_id_hi = '0; enq_id_lo = '0;
    @(negedge clk);
    tick(); tick();
    rst = 1'b0;
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL reset_iss_valid got=%b exp=0", iss_valid); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (enq_ready !== 1'b1) begin bad++; $display("FAIL reset_enq_ready got=%b exp=1", enq_ready); end
    total++; if (iss_id_hi !== 6'd0 || iss_op !== 2'd0) begin bad++; $display("FAIL reset_iss_fields got=%0d/%0d exp=0/0", iss_id_hi, iss_op); end
  endtask

  task automatic test_mul_ready();
    setEnq(2'd0, 6'd3, 1'b1, 6'd4, 1'b1, 6'd5);
    tick();
    enq_valid = 1'b0;
    total++; if (iss_valid !== 1'b0 || count !== 3'd1) begin bad++; $display("FAIL mul_enq got=%b/%0d exp=0/1", iss_valid, count); end
    total++; if (prf_raddr0 !== 6'd3 || prf_raddr1 !== 6'd4) begin bad++; $display("FAIL mul_raddr got=%0d/%0d exp=3/4", prf_raddr0, prf_raddr1); end
    tick();
    total++; if (iss_valid !== 1'b1 || iss_op !== 2'd0) begin bad++; $display("FAIL mul_issue got=%b/%0d exp=1/0", iss_valid, iss_op); end
    total++; if (iss_id_hi !== 6'd5 || iss_id_lo !== 6'd37 || iss_pdst_hi !== 6'd5 || iss_pdst_lo !== 6'd6) begin
      bad++; $display("FAIL mul_fields got=%0d/%0d/%0d/%0d exp=5/37/5/6", iss_id_hi, iss_id_lo, iss_pdst_hi, iss_pdst_lo); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL mul_count got=%0d exp=0", count); end
    idle(1);
    total++; if (iss_valid !== 1'b0 || iss_id_hi !== 6'd5) begin bad++; $display("FAIL mul_hold got=%b/%0d exp=0/5", iss_valid, iss_id_hi); end
  endtask

  task automatic test_reservation();
    idle(12);
    setEnq(2'd2, 6'd1, 1'b1, 6'd2, 1'b1, 6'd10);
    tick();
    setEnq(2'd0, 6'd1, 1'b1, 6'd2, 1'b1, 6'd11);
    tick();
    enq_valid = 1'b0;
    total++; if (iss_valid !== 1'b1 || iss_op !== 2'd2 || iss_id_hi !== 6'd10) begin bad++; $display("FAIL res_div_issue got=%b/%0d/%0d exp=1/2/10", iss_valid, iss_op, iss_id_hi); end
    tick();
    total++; if (iss_valid !== 1'b1 || iss_op !== 2'd0 || iss_id_hi !== 6'd11) begin bad++; $display("FAIL res_mul_free got=%b/%0d/%0d exp=1/0/11", iss_valid, iss_op, iss_id_hi); end
    // DIV issues at X; a MUL first attempting at X+4 collides until X+7.
    idle(12);
    setEnq(2'd3, 6'd1, 1'b1, 6'd2, 1'b1, 6'd12);
    tick();
    enq_valid = 1'b0;
    tick();
    total++; if (iss_valid !== 1'b1 || iss_op !== 2'd3) begin bad++; $display("FAIL res_divu_issue got=%b/%0d exp=1/3", iss_valid, iss_op); end
    tick(); tick();
    setEnq(2'd1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd13);
    tick();
    enq_valid = 1'b0;
    for (int k = 4; k <= 6; k++) begin
      tick();
      total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL res_mul_held k=%0d got=%b exp=0", k, iss_valid); end
    end
    tick();
    total++; if (iss_valid !== 1'b1 || iss_op !== 2'd1 || iss_id_hi !== 6'd13) begin bad++; $display("FAIL res_mul_release got=%b/%0d/%0d exp=1/1/13", iss_valid, iss_op, iss_id_hi); end
  endtask

  task automatic test_full_wakeup();
    logic [1:0] ops [4];
    ops[0] = 2'd0; ops[1] = 2'd2; ops[2] = 2'd1; ops[3] = 2'd3;
    idle(12);
    for (int i = 0; i < 4; i++) begin
      setEnq(ops[i], 6'd20, 1'b0, 6'd0, 1'b1, 6'(i + 20));
      tick();
    end
    enq_valid = 1'b0;
    total++; if (count !== 3'd4 || enq_ready !== 1'b0) begin bad++; $display("FAIL full_state got=%0d/%b exp=4/0", count, enq_ready); end
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL full_stalled got=%b exp=0", iss_valid); end
    wk_valid = 2'b10; wk_preg[1] = 6'd20;
    tick();
    wk_valid = 2'b00;
    total++; if (iss_valid !== 1'b0 || count !== 3'd4) begin bad++; $display("FAIL full_wake_edge got=%b/%0d exp=0/4", iss_valid, count); end
    // Offer a fifth pair while full: the issuing edge must not accept it.
    setEnq(2'd0, 6'd1, 1'b1, 6'd1, 1'b1, 6'd30);
    for (int i = 0; i < 4; i++) begin
      tick();
      enq_valid = 1'b0;
      total++; if (iss_valid !== 1'b1 || iss_op !== ops[i] || iss_id_hi !== 6'(i + 20)) begin
        bad++; $display("FAIL full_issue%0d got=%b/%0d/%0d exp=1/%0d/%0d", i, iss_valid, iss_op, iss_id_hi, ops[i], i + 20); end
      total++; if (count !== 3'(3 - i)) begin bad++; $display("FAIL full_count%0d got=%0d exp=%0d", i, count, 3 - i); end
    end
  endtask

  task automatic test_enq_wakeup();
    idle(12);
    setEnq(2'd0, 6'd7, 1'b0, 6'd8, 1'b0, 6'd14);
    wk_valid = 2'b11; wk_preg[0] = 6'd7; wk_preg[1] = 6'd8;
    tick();
    enq_valid = 1'b0; wk_valid = 2'b00;
    tick();
    total++; if (iss_valid !== 1'b1 || iss_id_hi !== 6'd14) begin bad++; $display("FAIL enq_wake got=%b/%0d exp=1/14", iss_valid, iss_id_hi); end
    idle(12);
    setEnq(2'd2, 6'd0, 1'b0, 6'd0, 1'b0, 6'd15);
    tick();
    enq_valid = 1'b0;
    tick();
    total++; if (iss_valid !== 1'b1 || iss_id_hi !== 6'd15) begin bad++; $display("FAIL preg0_ready got=%b/%0d exp=1/15", iss_valid, iss_id_hi); end
  endtask

  task automatic test_flush();
    idle(12);
    setEnq(2'd2, 6'd1, 1'b1, 6'd1, 1'b1, 6'd16);
    tick();
    for (int i = 0; i < 3; i++) begin
      setEnq(2'd0, 6'd9, 1'b0, 6'd1, 1'b1, 6'(i + 17));
      tick();
    end
    total++; if (count !== 3'd3) begin bad++; $display("FAIL flush_pre_count got=%0d exp=3", count); end
    flush = 1'b1;
    setEnq(2'd0, 6'd1, 1'b1, 6'd1, 1'b1, 6'd25);
    tick();
    flush = 1'b0; enq_valid = 1'b0;
    total++; if (count !== 3'd0 || iss_valid !== 1'b0 || enq_ready !== 1'b1) begin bad++; $display("FAIL flush_state got=%0d/%b/%b exp=0/0/1", count, iss_valid, enq_ready); end
    total++; if (iss_id_hi !== 6'd0) begin bad++; $display("FAIL flush_fields got=%0d exp=0", iss_id_hi); end
    setEnq(2'd0, 6'd1, 1'b1, 6'd1, 1'b1, 6'd26);
    tick();
    enq_valid = 1'b0;
    tick();
    total++; if (iss_valid !== 1'b1 || iss_id_hi !== 6'd26) begin bad++; $display("FAIL flush_new_mul got=%b/%0d exp=1/26", iss_valid, iss_id_hi); end
  endtask

  initial begin
    test_reset();
    test_mul_ready();
    test_reservation();
    test_full_wakeup();
    test_enq_wakeup();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
